// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: scheduler state encoding, WM8731 register map and power-up table.
// Rev 1.0
`default_nettype none

package codec_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5,
    RUN       = 3'd6
  } sched_state_e;

  localparam int N_REGS_DEFAULT = 11;

  localparam logic [6:0] REG_LLINE  = 7'h00;
  localparam logic [6:0] REG_RLINE  = 7'h01;
  localparam logic [6:0] REG_LHP    = 7'h02;
  localparam logic [6:0] REG_RHP    = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  // Reset first, activate last; interface word selects I2S 16-bit.
  localparam logic [15:0] INIT_TABLE [N_REGS_DEFAULT] = '{
    {REG_RESET,  9'h000},
    {REG_LLINE,  9'h017},
    {REG_RLINE,  9'h017},
    {REG_LHP,    9'h079},
    {REG_RHP,    9'h079},
    {REG_APATH,  9'h012},
    {REG_DPATH,  9'h000},
    {REG_PWR,    9'h000},
    {REG_IFACE,  9'h002},
    {REG_SRATE,  9'h000},
    {REG_ACTIVE, 9'h001}
  };

  // Left headphone register with LRHPBOTH set updates both channels; zero-cross off.
  function automatic logic [15:0] vol_word(input logic [6:0] vol);
    return {REG_LHP, 1'b1, 1'b0, vol};
  endfunction

endpackage

`default_nettype wire

// File: rtl/codec_reg_rom.sv
// codec_reg_rom: combinational index-to-word lookup over the codec init table.
// Rev 1.0
`default_nettype none

module codec_reg_rom
  import codec_cfg_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEFAULT,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0] index,
  output logic [15:0]      word
);

  always_comb begin
    word = 16'h0000;
    for (int i = 0; i < N_REGS; i++) begin
      if (index == IDX_W'(i)) word = INIT_TABLE[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/codec_i2c_scheduler.sv
// codec_i2c_scheduler: shares one I2C write engine between the init table and volume updates.
// Rev 1.0
`default_nettype none

module codec_i2c_scheduler
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         N_REGS     = N_REGS_DEFAULT,
  parameter int         GAP_CYCLES = 5000,
  parameter int         BUSY_TO    = 1024,
  parameter int         MAX_RETRY  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_vol_req,
  input  logic [6:0]  i_vol,
  input  logic        i_i2c_busy,
  input  logic        i_i2c_done,
  output logic        o_i2c_send_flag,
  output logic [7:0]  o_i2c_addr,
  output logic [15:0] o_i2c_data,
  output logic        o_busy,
  output logic        o_done_config,
  output logic        o_error
);

  localparam int IDX_W   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CNT_MAX = (GAP_CYCLES > BUSY_TO + 1) ? GAP_CYCLES : BUSY_TO + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_e       state, next_state;
  logic [IDX_W-1:0]   index;
  logic [RETRY_W-1:0] retry;
  logic [CNT_W-1:0]   cnt;
  logic               src_vol;
  logic               vol_pend;
  logic [6:0]         vol_val;
  logic               busy_q;
  logic [15:0]        data;
  logic               done_cfg;
  logic               error;
  logic [15:0]        rom_word;

  logic busy_timeout;
  logic gap_end;
  logic last_entry;
  logic engine_finished;

  codec_reg_rom #(
    .N_REGS (N_REGS),
    .IDX_W  (IDX_W)
  ) u_rom (
    .index (index),
    .word  (rom_word)
  );

  assign busy_timeout    = !i_i2c_busy && (cnt == CNT_W'(BUSY_TO));
  assign gap_end         = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign last_entry      = (index == IDX_W'(N_REGS - 1));
  assign engine_finished = i_i2c_done || (busy_q && !i_i2c_busy);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (i_start) next_state = LOAD;
      LOAD:      next_state = SEND;
      SEND:      next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (i_i2c_busy)        next_state = WAIT_DONE;
        else if (busy_timeout) next_state = (retry == RETRY_W'(MAX_RETRY)) ? IDLE : SEND;
      end
      WAIT_DONE: if (engine_finished) next_state = GAP;
      GAP:       if (gap_end) next_state = (!src_vol && !last_entry) ? LOAD : RUN;
      RUN:       if (i_start || vol_pend) next_state = LOAD;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      index    <= '0;
      retry    <= '0;
      cnt      <= '0;
      src_vol  <= 1'b0;
      vol_pend <= 1'b0;
      vol_val  <= 7'd0;
      busy_q   <= 1'b0;
      data     <= 16'h0000;
      done_cfg <= 1'b0;
      error    <= 1'b0;
    end else begin
      busy_q <= i_i2c_busy;

      // A request coinciding with the consuming LOAD wins over the clear.
      if (i_vol_req) begin
        vol_pend <= 1'b1;
        vol_val  <= i_vol;
      end else if (state == LOAD && src_vol) begin
        vol_pend <= 1'b0;
      end

      if ((state == WAIT_BUSY || state == GAP) && next_state == state) cnt <= cnt + CNT_W'(1);
      else                                                             cnt <= '0;

      case (state)
        IDLE, RUN: begin
          if (i_start) begin
            index    <= '0;
            done_cfg <= 1'b0;
            error    <= 1'b0;
            src_vol  <= 1'b0;
          end else if (state == RUN && vol_pend) begin
            src_vol <= 1'b1;
          end
        end
        LOAD: begin
          data  <= src_vol ? vol_word(vol_val) : rom_word;
          retry <= '0;
        end
        WAIT_BUSY: begin
          if (busy_timeout) begin
            if (retry == RETRY_W'(MAX_RETRY)) error <= 1'b1;
            else                              retry <= retry + RETRY_W'(1);
          end
        end
        GAP: begin
          if (gap_end && !src_vol) begin
            if (last_entry) done_cfg <= 1'b1;
            else            index    <= index + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_i2c_send_flag = (state == SEND);
    o_busy          = (state != IDLE) && (state != RUN);
    o_i2c_addr      = DEV_ADDR;
    o_i2c_data      = data;
    o_done_config   = done_cfg;
    o_error         = error;
  end

endmodule

`default_nettype wire
